// File: rtl/sklansky_adder_pipe.sv
// sklansky_adder_pipe: pipelined WIDTH-bit Sklansky prefix adder/subtractor with valid/ready handshake.
// Optional signed-overflow output enabled by defining SKLANSKY_OVF_EN.
module sklansky_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SKLANSKY_OVF_EN
    ,output logic            ovf
`endif
);
    localparam int LVL = $clog2(WIDTH);

    logic [LVL:0][WIDTH-1:0]   g_q;
    logic [LVL:0][WIDTH-1:0]   p_q;
    logic [LVL-1:0][WIDTH-1:0] pg_q;
    logic [LVL:0]              c0_q;
    logic [LVL:0]              v_q;
    logic [LVL:1][WIDTH-1:0]   gn;
    logic [LVL-1:1][WIDTH-1:0] pn;
    logic [WIDTH-1:0]          bx, gi, pi;
    logic                      stall, hi;
    int                        lo;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign bx       = sub ? ~b : b;

    // Column 0 folds c0 into its generate before level 1, so every grey cell
    // reaching column 0 already produces the true carry including c0.
    always_comb begin
        gn = '0;
        pn = '0;
        gi = '0;
        pi = '0;
        hi = 1'b0;
        lo = 0;
        for (int k = 1; k <= LVL; k++) begin
            gi = g_q[k-1];
            pi = k < LVL ? pg_q[k-1] : '0;
            if (k == 1) gi[0] = g_q[0][0] | pg_q[0][0] & c0_q[0];
            if (k == LVL) pi = pg_q[LVL-1];
            for (int j = 0; j < WIDTH; j++) begin
                hi = ((j >> (k - 1)) & 1) == 1;
                lo = hi ? ((j >> (k - 1)) << (k - 1)) - 1 : j;
                gn[k][j] = hi ? gi[j] | pi[j] & gi[lo] : gi[j];
                if (k < LVL) pn[k][j] = hi ? (j < (1 << k) ? 1'b0 : pi[j] & pi[lo]) : pi[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            g_q[0]  <= a & bx;
            p_q[0]  <= a ^ bx;
            pg_q[0] <= a ^ bx;
            c0_q[0] <= cin ^ sub;
            v_q[0]  <= in_valid;
            for (int k = 1; k <= LVL; k++) begin
                g_q[k]  <= gn[k];
                p_q[k]  <= p_q[k-1];
                c0_q[k] <= c0_q[k-1];
                v_q[k]  <= v_q[k-1];
                if (k < LVL) pg_q[k] <= pn[k];
            end
            out_valid <= v_q[LVL];
        end
        if (!stall && v_q[LVL]) begin
            sum  <= p_q[LVL] ^ {g_q[LVL][WIDTH-2:0], c0_q[LVL]};
            cout <= g_q[LVL][WIDTH-1];
`ifdef SKLANSKY_OVF_EN
            ovf  <= g_q[LVL][WIDTH-1] ^ g_q[LVL][WIDTH-2];
`endif
        end
        if (rst) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SKLANSKY_OVF_EN
            ovf       <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_sklansky_adder_pipe.sv
// tb_sklansky_adder_pipe: directed and random checks of the pipelined Sklansky adder
// at WIDTH=16 (with stalls and reset) and WIDTH=4 (exhaustive).
module tb_sklansky_adder_pipe;
    localparam int W = 16, L = 4, W4 = 4, L4 = 2;
`ifdef SKLANSKY_OVF_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, cout, ovb;
    logic [W-1:0] a = '0, b = '0, sum;
    logic          iv4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
    logic          ir4, ov4, c4, ovb4;
    logic [W4-1:0] a4 = '0, b4 = '0, s4;

`ifdef SKLANSKY_OVF_EN
    logic ovf, ovf4;
    assign ovb  = ovf;
    assign ovb4 = ovf4;
`else
    assign ovb  = 1'b0;
    assign ovb4 = 1'b0;
`endif

    sklansky_adder_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SKLANSKY_OVF_EN
        , .ovf(ovf)
`endif
    );

    sklansky_adder_pipe #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(ov4), .out_ready(1'b1), .sum(s4), .cout(c4)
`ifdef SKLANSKY_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // Result layout: [17]=ovf, [16]=cout, [15:0]=sum
    logic [17:0] expq[$], gotq[$], exp4[$], got4[$];
    int          acc4[$], out4c[$];
    int          errs = 0, checks = 0, cyc = 0;
    int          rdy_bad = 0, hold_bad = 0, rdy4_bad = 0;
    bit          rnd_rdy = 1'b0, prev_stall = 1'b0;
    logic [17:0] prev_out;

    function automatic logic [17:0] model(input int w, input longint x, y, input bit ci, sb);
        longint m, h, r, rs, sx, sy, c;
        model = '0;
        m  = longint'(1) << w;
        h  = m / 2;
        c  = longint'(ci);
        sx = x >= h ? x - m : x;
        sy = y >= h ? y - m : y;
        r  = sb ? x - y - c : x + y + c;
        rs = sb ? sx - sy - c : sx + sy + c;
        model[15:0] = 16'(r & (m - 1));
        model[16]   = sb ? r >= 0 : r >= m;
        model[17]   = OV && (rs < -h || rs >= h);
    endfunction

    task automatic chk(input string t, input logic [63:0] o, e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", t, o, e);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) gotq.push_back({ovb, cout, sum});
            if (in_ready !== !(out_valid && !out_ready)) rdy_bad++;
            if (prev_stall && {ovb, cout, sum} !== prev_out) hold_bad++;
            prev_stall = out_valid && !out_ready;
            prev_out   = {ovb, cout, sum};
            if (ov4) begin
                got4.push_back({ovb4, c4, 12'b0, s4});
                out4c.push_back(cyc);
            end
            if (ir4 !== 1'b1) rdy4_bad++;
        end else prev_stall = 1'b0;
    end

    task automatic send(input logic [W-1:0] x, y, input logic ci, sb);
        int n = 0;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("send_accept", 64'(n < 200), 64'd1);
        expq.push_back(model(W, x, y, ci, sb));
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string t);
        int n = 0;
        while (gotq.size() < expq.size() && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (L + 4) @(posedge clk);
        #2;
        chk({t, "_count"}, 64'(gotq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) chk(t, 64'(gotq[i]), 64'(expq[i]));
        gotq.delete();
        expq.delete();
    endtask

    initial begin
        int n, lat4_bad;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovb), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        expq.push_back(model(W, 16'h1234, 16'h1111, 1'b0, 1'b0));
        @(posedge clk);
        #2 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t1_latency", 64'(n), 64'(L + 2));
        chk("t1_sum", 64'(sum), 64'h2345);
        chk("t1_cout", 64'(cout), 64'd0);
        @(posedge clk);
        #2 chk("t1_pulse", 64'(out_valid), 64'd0);
        drain("t1");

        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        drain("directed");

        rnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
            end else send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        drain("random");
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        chk("in_ready_vs_stall", 64'(rdy_bad), 64'd0);
        chk("hold_on_stall", 64'(hold_bad), 64'd0);

        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b0);
        send(16'h5555, 16'h0001, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        expq.delete();
        repeat (20) @(posedge clk);
        #2 chk("no_stale", 64'(gotq.size()), 64'd0);

        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++) begin
                        a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); sub4 = 1'(s); iv4 = 1'b1;
                        exp4.push_back(model(W4, longint'(x), longint'(y), 1'(c), 1'(s)));
                        acc4.push_back(cyc);
                        @(posedge clk);
                        #2;
                    end
        iv4 = 1'b0;
        n = 0;
        while (got4.size() < exp4.size() && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #2;
        chk("w4_count", 64'(got4.size()), 64'(exp4.size()));
        lat4_bad = 0;
        for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
            chk("w4_result", 64'(got4[i]), 64'(exp4[i]));
            if (out4c[i] - acc4[i] != L4 + 2) lat4_bad++;
        end
        chk("w4_latency", 64'(lat4_bad), 64'd0);
        chk("w4_in_ready", 64'(rdy4_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
